ext_mem_port: RTL

- Responder for the external memory-access interface driven by the host/bench: IRAM load (start_2), DRAM load (start_3), DRAM readback (start_4).
- Sits in top_control between the host strobes and the IRAM/DRAM macros; muxes the memory ports between host and processor.
- Converts level-held host strobes into single-cycle memory writes/reads and returns latched read data.
- Blocks host access while the processor runs (start=1).

---
 rtl/ext_mem_port_pkg.sv | 33 +++
 rtl/ext_mem_port_strobe_sync_edge.sv | 26 ++
 rtl/ext_mem_port.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_port_pkg.sv
// Shared types for the external memory port: access mode and host read FSM encodings.
// Pure declarations; no latency, no backpressure.
package ext_mem_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        MODE_IDLE    = 3'd0,
        MODE_RUN     = 3'd1,
        MODE_IRAM_LD = 3'd2,
        MODE_DRAM_LD = 3'd3,
        MODE_DRAM_RD = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DONE = 2'd2
    } rd_state_t;

    function automatic mode_t decode_mode(input logic run, input logic ld_i,
                                          input logic ld_d, input logic rd_d);
        mode_t m;
        if (run)       m = MODE_RUN;
        else if (ld_i) m = MODE_IRAM_LD;
        else if (ld_d) m = MODE_DRAM_LD;
        else if (rd_d) m = MODE_DRAM_RD;
        else           m = MODE_IDLE;
        return m;
    endfunction

endpackage

// File: rtl/ext_mem_port_strobe_sync_edge.sv
// Two-flop synchroniser for a level host strobe plus a one-cycle rising-edge pulse.
// Pulse appears in the cycle after the second sync flop goes high; no backpressure.
module strobe_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic i_strobe,
    output logic o_pulse
);

    logic r_s1, r_s2, r_s3;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_strobe;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/ext_mem_port.sv
// Host/processor mux for IRAM/DRAM: host strobes become single writes 3 cycles after rising, reads return after RD_LAT+4.
// No backpressure; misuse sets sticky ext_err. Optional EXT_WR_COUNT_EN adds host write counters.
module ext_mem_port
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              start_2,
    input  logic              start_3,
    input  logic              start_4,
    input  logic [ADDR_W-1:0] addr_ext,
    input  logic              iram_write_ext,
    input  logic              dram_write_ext,
    input  logic              read_en_ext,
    input  logic [DATA_W-1:0] Data_in_ins,
    input  logic [DATA_W-1:0] Data_in_dram,
    input  logic [ADDR_W-1:0] proc_iram_addr,
    input  logic [ADDR_W-1:0] proc_dram_addr,
    input  logic [DATA_W-1:0] proc_dram_wdata,
    input  logic              proc_dram_we,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [DATA_W-1:0] iram_wdata,
    output logic              iram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic [DATA_W-1:0] dram_in,
    output logic              rd_valid,
    output logic              ext_err
`ifdef EXT_WR_COUNT_EN
    ,
    output logic [15:0]       iram_wr_cnt,
    output logic [15:0]       dram_wr_cnt
`endif
);

    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    mode_t       w_mode;
    logic        w_host_mode;
    logic        w_iw_pulse, w_dw_pulse, w_rd_pulse;
    logic        w_iw_ok, w_dw_ok, w_rd_ok, w_err_evt, w_enter_idle;

    logic              r_live;
    mode_t             r_mode_q;
    logic [ADDR_W-1:0] r_h_iram_addr, r_h_dram_addr;
    logic [DATA_W-1:0] r_h_iram_wdata, r_h_dram_wdata;
    logic              r_h_iram_we, r_h_dram_we;
    rd_state_t         r_rd_state;
    logic [1:0]        r_wait_cnt;
    logic              r_rd_keep;
    logic [DATA_W-1:0] r_dram_in;
    logic              r_rd_valid;
    logic              r_ext_err;

    assign w_mode      = decode_mode(start, start_2, start_3, start_4);
    assign w_host_mode = (w_mode != MODE_RUN) && (w_mode != MODE_IDLE);

    strobe_sync_edge u_iw_sync (.clock(clock), .reset_n(reset_n), .i_strobe(iram_write_ext), .o_pulse(w_iw_pulse));
    strobe_sync_edge u_dw_sync (.clock(clock), .reset_n(reset_n), .i_strobe(dram_write_ext), .o_pulse(w_dw_pulse));
    strobe_sync_edge u_rd_sync (.clock(clock), .reset_n(reset_n), .i_strobe(read_en_ext),    .o_pulse(w_rd_pulse));

    // An edge is honoured only in its own mode; reads also need an idle FSM.
    assign w_iw_ok      = w_iw_pulse && (w_mode == MODE_IRAM_LD);
    assign w_dw_ok      = w_dw_pulse && (w_mode == MODE_DRAM_LD);
    assign w_rd_ok      = w_rd_pulse && (w_mode == MODE_DRAM_RD) && (r_rd_state == R_IDLE);
    assign w_err_evt    = (w_iw_pulse && !w_iw_ok) || (w_dw_pulse && !w_dw_ok) || (w_rd_pulse && !w_rd_ok);
    assign w_enter_idle = (w_mode == MODE_IDLE) && (r_mode_q != MODE_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_live    <= 1'b0;
            r_mode_q  <= MODE_IDLE;
            r_ext_err <= 1'b0;
        end else begin
            r_live   <= 1'b1;
            r_mode_q <= w_mode;
            if (w_err_evt)         r_ext_err <= 1'b1;
            else if (w_enter_idle) r_ext_err <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_h_iram_addr  <= '0;
            r_h_iram_wdata <= '0;
            r_h_iram_we    <= 1'b0;
            r_h_dram_addr  <= '0;
            r_h_dram_wdata <= '0;
            r_h_dram_we    <= 1'b0;
        end else begin
            r_h_iram_we <= w_iw_ok;
            r_h_dram_we <= w_dw_ok;
            if (w_iw_ok) begin
                r_h_iram_addr  <= addr_ext;
                r_h_iram_wdata <= Data_in_ins;
            end
            if (w_dw_ok) begin
                r_h_dram_addr  <= addr_ext;
                r_h_dram_wdata <= Data_in_dram;
            end else if (w_rd_ok) begin
                r_h_dram_addr  <= addr_ext;
            end
        end
    end

    // Read result is kept only if the port stayed in DRAM_RD for the whole access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_state <= R_IDLE;
            r_wait_cnt <= '0;
            r_rd_keep  <= 1'b0;
            r_dram_in  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_rd_state)
                R_IDLE: begin
                    if (w_rd_ok) begin
                        r_rd_state <= R_WAIT;
                        r_wait_cnt <= '0;
                        r_rd_keep  <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (w_mode != MODE_DRAM_RD) r_rd_keep <= 1'b0;
                    if (r_wait_cnt == RD_LAST) r_rd_state <= R_DONE;
                    else                       r_wait_cnt <= r_wait_cnt + 2'd1;
                end
                R_DONE: begin
                    if (r_rd_keep && (w_mode == MODE_DRAM_RD)) begin
                        r_dram_in  <= dram_rdata;
                        r_rd_valid <= 1'b1;
                    end
                    r_rd_keep  <= 1'b0;
                    r_rd_state <= R_IDLE;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // r_live forces every port to zero while reset is held, even the pass-through path.
    always_comb begin
        iram_addr  = '0;
        iram_wdata = '0;
        iram_we    = 1'b0;
        dram_addr  = '0;
        dram_wdata = '0;
        dram_we    = 1'b0;
        if (r_live) begin
            if (w_host_mode) begin
                iram_addr  = r_h_iram_addr;
                iram_wdata = r_h_iram_wdata;
                iram_we    = r_h_iram_we;
                dram_addr  = r_h_dram_addr;
                dram_wdata = r_h_dram_wdata;
                dram_we    = r_h_dram_we;
            end else begin
                iram_addr  = proc_iram_addr;
                dram_addr  = proc_dram_addr;
                dram_wdata = proc_dram_wdata;
                dram_we    = proc_dram_we;
            end
        end
    end

    assign dram_in  = r_dram_in;
    assign rd_valid = r_rd_valid;
    assign ext_err  = r_ext_err;

`ifdef EXT_WR_COUNT_EN
    logic [15:0] r_iram_wr_cnt, r_dram_wr_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_iram_wr_cnt <= '0;
            r_dram_wr_cnt <= '0;
        end else begin
            if ((w_mode == MODE_IRAM_LD) && (r_mode_q != MODE_IRAM_LD))
                r_iram_wr_cnt <= '0;
            else if (r_h_iram_we && (r_iram_wr_cnt != 16'hFFFF))
                r_iram_wr_cnt <= r_iram_wr_cnt + 16'd1;
            if ((w_mode == MODE_DRAM_LD) && (r_mode_q != MODE_DRAM_LD))
                r_dram_wr_cnt <= '0;
            else if (r_h_dram_we && (r_dram_wr_cnt != 16'hFFFF))
                r_dram_wr_cnt <= r_dram_wr_cnt + 16'd1;
        end
    end

    assign iram_wr_cnt = r_iram_wr_cnt;
    assign dram_wr_cnt = r_dram_wr_cnt;
`endif

endmodule
